// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared definitions for the programmable clock divider.
//   MIN_DIV    - smallest divisor a channel will ever run at
//   clamp_div  - maps requested divisors 0 and 1 up to MIN_DIV
//   ch_state_e - per-channel run state (IDLE, RUN)
package clkdiv_pkg;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Divisors below MIN_DIV cannot produce a high and a low phase, so they
  // are raised to MIN_DIV. Callers zero-extend their divisor to 32 bits.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel (shadow divisor, counter, run FSM).
//   sys_clk  in  system clock, rising edge
//   rst      in  synchronous active-high reset
//   en       in  run enable, honoured only at period boundaries
//   div_in   in  divisor value presented for capture
//   div_load in  capture strobe for div_in into the shadow divisor
//   resync   in  restart strobe, affects running or enabled channels
//   clk_out  out divided clock, high for ceil(N/2) of every N cycles
//   tick     out high during the last cycle of each period
//   active   out channel is running
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  input  logic                 resync,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 active
);

  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_X   = (DIV_WIDTH+1)'(1);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  ch_state_e              state_reg,   state_next;
  logic [DIV_WIDTH-1:0]   count_reg,   count_next;
  logic [DIV_WIDTH-1:0]   cur_div_reg, cur_div_next;
  logic [DIV_WIDTH-1:0]   shadow_reg,  shadow_next;
  logic                   clk_out_reg, clk_out_next;
  logic                   tick_reg,    tick_next;

  logic [DIV_WIDTH:0]     high_len;
  logic [DIV_WIDTH:0]     count_inc;
  logic                   wrap;

  always_comb begin
    // A load on the same edge as a divisor pickup bypasses the shadow.
    shadow_next  = div_load ? DIV_WIDTH'(clamp_div(32'(div_in))) : shadow_reg;

    // One extra bit so (cur_div+1) cannot overflow at the top of the range.
    high_len     = ({1'b0, cur_div_reg} + ONE_X) >> 1;
    count_inc    = {1'b0, count_reg} + ONE_X;
    wrap         = (count_reg == cur_div_reg - ONE);

    state_next   = state_reg;
    count_next   = count_reg;
    cur_div_next = cur_div_reg;
    clk_out_next = clk_out_reg;

    if (resync && (state_reg == RUN || en)) begin
      state_next   = RUN;
      count_next   = '0;
      clk_out_next = 1'b1;
      cur_div_next = shadow_next;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_next   = RUN;
            count_next   = '0;
            clk_out_next = 1'b1;
            cur_div_next = shadow_next;
          end
        end
        RUN: begin
          if (wrap) begin
            count_next = '0;
            if (en) begin
              clk_out_next = 1'b1;
              cur_div_next = shadow_next;
            end else begin
              // Stopping only here means the last period is never cut short.
              state_next   = IDLE;
              clk_out_next = 1'b0;
            end
          end else begin
            count_next   = count_inc[DIV_WIDTH-1:0];
            clk_out_next = (count_inc < high_len);
          end
        end
        default: begin
          state_next   = IDLE;
          count_next   = '0;
          clk_out_next = 1'b0;
        end
      endcase
    end

    // Computed from next state so the registered tick lines up with count.
    tick_next = (state_next == RUN) && (count_next == cur_div_next - ONE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      cur_div_reg <= DEF_DIV;
      shadow_reg  <= DEF_DIV;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      cur_div_reg <= cur_div_next;
      shadow_reg  <= shadow_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign active  = (state_reg == RUN);

endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NUM_CH independent runtime-programmable dividers.
//   sys_clk  in  system clock, rising edge
//   rst      in  synchronous active-high reset
//   en       in  [NUM_CH] per-channel run enable
//   div_in   in  [NUM_CH*DIV_WIDTH] packed divisors, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   div_load in  [NUM_CH] per-channel divisor capture strobe
//   resync   in  restart all running/enabled channels at phase 0
//   clk_out  out [NUM_CH] registered divided clocks
//   tick     out [NUM_CH] one-cycle end-of-period pulses
//   active   out [NUM_CH] channel running flags
// DIV_WIDTH is limited to 32 by the package clamp helper.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           en,
  input  logic [NUM_CH*DIV_WIDTH-1:0] div_in,
  input  logic [NUM_CH-1:0]           div_load,
  input  logic                        resync,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           active
);

  if (DEFAULT_DIV < int'(MIN_DIV) ||
      longint'(DEFAULT_DIV) >= (longint'(1) << DIV_WIDTH)) begin : g_bad_default
    $error("prog_clock_divider: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**DIV_WIDTH");
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clkdiv_channel #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .en       (en[gi]),
        .div_in   (div_in[gi*DIV_WIDTH +: DIV_WIDTH]),
        .div_load (div_load[gi]),
        .resync   (resync),
        .clk_out  (clk_out[gi]),
        .tick     (tick[gi]),
        .active   (active[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: the driver pushes per-edge expectations from a
// position-based reference model; the monitor pops and compares after each edge.
module tb_prog_clock_divider;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DEF = 4;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en;
  logic [NCH*DW-1:0] div_in;
  logic [NCH-1:0]    div_load;
  logic              resync;
  logic [NCH-1:0]    clk_out, tick, active;

  prog_clock_divider #(.NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .resync   (resync),
    .clk_out  (clk_out),
    .tick     (tick),
    .active   (active)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [NCH-1:0] clk;
    logic [NCH-1:0] tck;
    logic [NCH-1:0] act;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: each channel is a position within a period of length n.
  bit m_run[NCH];
  int m_pos[NCH];
  int m_n[NCH];
  int m_sh[NCH];

  // Stimulus held between steps
  logic              rst_v;
  logic [NCH-1:0]    en_v, load_v;
  logic [NCH*DW-1:0] div_v;
  logic              rs_v;

  function automatic int clampv(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      if (rst_v) begin
        m_run[i] = 0; m_pos[i] = 0; m_n[i] = DEF; m_sh[i] = DEF;
      end else begin
        if (load_v[i]) m_sh[i] = clampv(int'(div_v[i*DW +: DW]));
        if ((rs_v && (m_run[i] || en_v[i])) || (!m_run[i] && en_v[i])) begin
          m_run[i] = 1; m_pos[i] = 0; m_n[i] = m_sh[i];
        end else if (m_run[i]) begin
          if (m_pos[i] == m_n[i] - 1) begin
            m_pos[i] = 0;
            if (en_v[i]) m_n[i] = m_sh[i];
            else         m_run[i] = 0;
          end else begin
            m_pos[i]++;
          end
        end
      end
    end
  endtask

  // Apply held stimulus for one edge and record what that edge must produce.
  task automatic step();
    exp_t e;
    @(negedge sys_clk);
    rst = rst_v; en = en_v; div_in = div_v; div_load = load_v; resync = rs_v;
    model_edge();
    for (int i = 0; i < NCH; i++) begin
      e.act[i] = m_run[i];
      e.clk[i] = m_run[i] && (m_pos[i] < (m_n[i] + 1) / 2);
      e.tck[i] = m_run[i] && (m_pos[i] == m_n[i] - 1);
    end
    cyc++;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic steps(int k);
    for (int j = 0; j < k; j++) step();
  endtask

  task automatic load1(int ch, int val);
    div_v[ch*DW +: DW] = DW'(val);
    load_v = '0; load_v[ch] = 1'b1;
    step();
    load_v = '0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (clk_out !== e.clk) begin
          errors++;
          $display("FAIL clk_out cyc=%0d got=%b exp=%b", e.cyc, clk_out, e.clk);
        end
        tests++;
        if (tick !== e.tck) begin
          errors++;
          $display("FAIL tick cyc=%0d got=%b exp=%b", e.cyc, tick, e.tck);
        end
        tests++;
        if (active !== e.act) begin
          errors++;
          $display("FAIL active cyc=%0d got=%b exp=%b", e.cyc, active, e.act);
        end
      end
    end
  end

  initial begin
    int guard;
    rst_v = 1'b1; en_v = '0; load_v = '0; div_v = '0; rs_v = 1'b0;
    rst = 1'b1; en = '0; div_in = '0; div_load = '0; resync = 1'b0;

    // Reset, then channel 0 at the default divisor of 4
    steps(3);
    rst_v = 1'b0;
    steps(2);
    en_v[0] = 1'b1;
    steps(9);

    // Mid-period load of 5 while running at 4
    load1(0, 5);
    steps(14);

    // Degenerate divisors clamp to 2
    load1(0, 0);
    steps(7);
    load1(0, 1);
    steps(7);

    // Channel 1 at N=6, enable dropped at count 1
    load1(1, 6);
    en_v[1] = 1'b1;
    step();
    guard = 0;
    while (m_pos[1] != 0 && guard < 20) begin step(); guard++; end
    step();
    en_v[1] = 1'b0;
    steps(12);

    // All channels at 3,4,5,7, then resync
    div_v = {DW'(7), DW'(5), DW'(4), DW'(3)};
    load_v = '1; step(); load_v = '0;
    en_v = '1;
    steps(25);
    rs_v = 1'b1; step(); rs_v = 1'b0;
    steps(20);

    // Reset during a high phase with load and resync also asserted
    guard = 0;
    while (!(m_run[0] && m_pos[0] == 0) && guard < 20) begin step(); guard++; end
    rst_v = 1'b1; load_v = '1; rs_v = 1'b1; div_v = {4{DW'(9)}};
    step();
    rst_v = 1'b0; load_v = '0; rs_v = 1'b0;
    en_v = '0;
    steps(3);
    en_v = '1;
    steps(10);

    // Randomized traffic with small divisors
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        div_v[i*DW +: DW] = DW'($urandom_range(0, 9));
        load_v[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 15) == 0) en_v[i] = ~en_v[i];
      end
      rs_v  = ($urandom_range(0, 49) == 0);
      rst_v = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_v = 1'b0; load_v = '0; rs_v = 1'b0;

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge sys_clk);
      guard++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
